// File: rtl/reset_sequencer.sv
// reset_sequencer
// Staged reset controller: holds every subsystem in reset for a power-on
// interval, then releases DDR, network and SoC in order, waiting for each
// completion indication. A missing indication times out and restarts the
// sequence; too many timeouts park the controller in FAIL until sys_rst_i.
// All outputs come straight from flops, updated on the same edge as the
// state so they always match state_o.

`timescale 1ns/1ps

module reset_sequencer #(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned POR_CYCLES     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       ddr_calib_done_i,
    input  logic       net_resetdone_i,
    output logic       ddr_rst_o,
    output logic       net_rst_o,
    output logic       soc_rst_n_o,
    output logic       resetdone_o,
    output logic       timeout_o,
    output logic       fail_o,
    output logic [2:0] state_o
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   POR_LAST   = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ZERO = RETRY_W'(0);
    localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);

    typedef enum logic [2:0] {
        ST_POR      = 3'd0,
        ST_DDR_WAIT = 3'd1,
        ST_NET_WAIT = 3'd2,
        ST_SOC_GAP  = 3'd3,
        ST_RUN      = 3'd4,
        ST_FAIL     = 3'd5
    } state_t;

    // Synchronizer flops for the asynchronous completion inputs
    logic ddr_sync1_r;
    logic ddr_sync2_r;
    logic net_sync1_r;
    logic net_sync2_r;

    // FSM state and its bookkeeping
    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_nxt_s;
    logic [RETRY_W-1:0] retry_inc_s;
    logic               timeout_evt_s;

    // Output values decoded from the next state, and their registers
    logic ddr_rst_s;
    logic net_rst_s;
    logic soc_rst_n_s;
    logic resetdone_s;
    logic timeout_s;
    logic fail_s;
    logic ddr_rst_r;
    logic net_rst_r;
    logic soc_rst_n_r;
    logic resetdone_r;
    logic timeout_r;
    logic fail_r;

    // Two-flop synchronizers; cleared by reset so stale highs never leak in
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ddr_sync1_r <= 1'b0;
            ddr_sync2_r <= 1'b0;
            net_sync1_r <= 1'b0;
            net_sync2_r <= 1'b0;
        end else begin
            ddr_sync1_r <= ddr_calib_done_i;
            ddr_sync2_r <= ddr_sync1_r;
            net_sync1_r <= net_resetdone_i;
            net_sync2_r <= net_sync1_r;
        end
    end

    // State, counter and retry registers
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_r <= ST_POR;
            cnt_r   <= CNT_ZERO;
            retry_r <= RETRY_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            retry_r <= retry_nxt_s;
        end
    end

    // Saturating retry increment used by the timeout action
    always_comb begin
        if (retry_r == RETRY_MAX) begin
            retry_inc_s = retry_r;
        end else begin
            retry_inc_s = retry_r + RETRY_ONE;
        end
    end

    // Next-state logic: terminal counts, done handling (done beats timeout)
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        retry_nxt_s   = retry_r;
        timeout_evt_s = 1'b0;
        case (state_r)
            ST_POR: begin
                if (cnt_r == POR_LAST) begin
                    state_nxt_s = ST_DDR_WAIT;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DDR_WAIT: begin
                if (ddr_sync2_r) begin
                    state_nxt_s = ST_NET_WAIT;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == TO_LAST) begin
                    timeout_evt_s = 1'b1;
                    retry_nxt_s   = retry_inc_s;
                    cnt_nxt_s     = CNT_ZERO;
                    state_nxt_s   = (retry_inc_s == RETRY_MAX) ? ST_FAIL : ST_POR;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_NET_WAIT: begin
                if (net_sync2_r) begin
                    state_nxt_s = ST_SOC_GAP;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == TO_LAST) begin
                    timeout_evt_s = 1'b1;
                    retry_nxt_s   = retry_inc_s;
                    cnt_nxt_s     = CNT_ZERO;
                    state_nxt_s   = (retry_inc_s == RETRY_MAX) ? ST_FAIL : ST_POR;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_SOC_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_nxt_s = CNT_ZERO;
                if (!ddr_sync2_r || !net_sync2_r) begin
                    state_nxt_s = ST_POR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FAIL: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_FAIL;
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_POR;
            end
        endcase
    end

    // Output decode from the next state so registered outputs track state_o
    always_comb begin
        ddr_rst_s   = 1'b1;
        net_rst_s   = 1'b1;
        soc_rst_n_s = 1'b0;
        resetdone_s = 1'b0;
        fail_s      = 1'b0;
        timeout_s   = timeout_r | timeout_evt_s;
        case (state_nxt_s)
            ST_POR: begin
                ddr_rst_s = 1'b1;
            end
            ST_DDR_WAIT: begin
                ddr_rst_s = 1'b0;
            end
            ST_NET_WAIT, ST_SOC_GAP: begin
                ddr_rst_s = 1'b0;
                net_rst_s = 1'b0;
            end
            ST_RUN: begin
                ddr_rst_s   = 1'b0;
                net_rst_s   = 1'b0;
                soc_rst_n_s = 1'b1;
                resetdone_s = 1'b1;
            end
            ST_FAIL: begin
                fail_s = 1'b1;
            end
            default: begin
                ddr_rst_s = 1'b1;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ddr_rst_r   <= 1'b1;
            net_rst_r   <= 1'b1;
            soc_rst_n_r <= 1'b0;
            resetdone_r <= 1'b0;
            timeout_r   <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            ddr_rst_r   <= ddr_rst_s;
            net_rst_r   <= net_rst_s;
            soc_rst_n_r <= soc_rst_n_s;
            resetdone_r <= resetdone_s;
            timeout_r   <= timeout_s;
            fail_r      <= fail_s;
        end
    end

    assign ddr_rst_o   = ddr_rst_r;
    assign net_rst_o   = net_rst_r;
    assign soc_rst_n_o = soc_rst_n_r;
    assign resetdone_o = resetdone_r;
    assign timeout_o   = timeout_r;
    assign fail_o      = fail_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. Stimulus pushes the expected
// {state, ddr_rst, net_rst, soc_rst_n, resetdone, timeout, fail} for a given
// edge number; a monitor pops and compares after each clock edge.

`timescale 1ns/1ps

module tb_reset_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       ddr_done;
    logic       net_done;
    logic       ddr_rst;
    logic       net_rst;
    logic       soc_rst_n;
    logic       resetdone;
    logic       timeout;
    logic       fail;
    logic [2:0] state;

    reset_sequencer #(
        .CNT_W          (24),
        .POR_CYCLES     (8),
        .TIMEOUT_CYCLES (32),
        .STAGE_GAP      (4),
        .MAX_RETRIES    (2)
    ) dut (
        .sys_clk_i        (sys_clk),
        .sys_rst_i        (sys_rst),
        .ddr_calib_done_i (ddr_done),
        .net_resetdone_i  (net_done),
        .ddr_rst_o        (ddr_rst),
        .net_rst_o        (net_rst),
        .soc_rst_n_o      (soc_rst_n),
        .resetdone_o      (resetdone),
        .timeout_o        (timeout),
        .fail_o           (fail),
        .state_o          (state)
    );

    always #5 sys_clk = ~sys_clk;

    // Absolute edge counter
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct packed {
        int         at;
        logic [8:0] val;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    base   = 0;
    int    n_pass = 0;
    int    n_tot  = 0;

    // Expected outputs after scenario edge n; o = {ddr,net,socn,done,to,fail}
    task automatic chk(input int n, input string nm, input logic [2:0] st, input logic [5:0] o);
        exp_t e;
        e.at  = base + n;
        e.val = {st, o};
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic goto(input int n);
        while (cyc < base + n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // One reset edge; scenario edge 0 is the next edge
    task automatic do_reset();
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        base = cyc + 1;
        chk(-1, "reset_state", 3'd0, 6'b110000);
    endtask

    // Monitor: compare every expectation due at this edge
    initial begin
        exp_t       e;
        string      nm;
        logic [8:0] act;
        forever begin
            @(negedge sys_clk);
            act = {state, ddr_rst, net_rst, soc_rst_n, resetdone, timeout, fail};
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                n_tot = n_tot + 1;
                if (e.at < cyc) begin
                    $display("FAIL %s: check for cycle %0d reached only at cycle %0d", nm, e.at, cyc);
                end else if (act !== e.val) begin
                    $display("FAIL %s at cycle %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                             nm, cyc, act[8:6], act[5:0], e.val[8:6], e.val[5:0]);
                end else begin
                    n_pass = n_pass + 1;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        sys_rst  = 1'b1;
        ddr_done = 1'b0;
        net_done = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        // Nominal sequence, then net done lost in RUN and a full re-sequence
        do_reset();
        chk(6,  "por_hold",      3'd0, 6'b110000);
        chk(7,  "ddr_release",   3'd1, 6'b010000);
        chk(13, "ddr_wait_sync", 3'd1, 6'b010000);
        chk(14, "net_release",   3'd2, 6'b000000);
        chk(22, "soc_gap",       3'd3, 6'b000000);
        chk(25, "soc_gap_end",   3'd3, 6'b000000);
        chk(26, "run",           3'd4, 6'b001100);
        chk(32, "run_held",      3'd4, 6'b001100);
        chk(33, "run_lost_net",  3'd0, 6'b110000);
        chk(41, "reseq_ddr",     3'd1, 6'b010000);
        chk(42, "reseq_net",     3'd2, 6'b000000);
        chk(43, "reseq_gap",     3'd3, 6'b000000);
        chk(46, "reseq_gap_end", 3'd3, 6'b000000);
        chk(47, "reseq_run",     3'd4, 6'b001100);
        goto(11); ddr_done = 1'b1;
        goto(19); net_done = 1'b1;
        goto(30); net_done = 1'b0;
        goto(34); net_done = 1'b1;
        goto(47);

        // Retry then fail, then FAIL absorbing under toggling inputs
        ddr_done = 1'b0;
        net_done = 1'b0;
        do_reset();
        chk(38,  "to1_pending",  3'd1, 6'b010000);
        chk(39,  "to1",          3'd0, 6'b110010);
        chk(47,  "retry_ddr",    3'd1, 6'b010010);
        chk(78,  "to2_pending",  3'd1, 6'b010010);
        chk(79,  "fail",         3'd5, 6'b110011);
        chk(100, "fail_hold_a",  3'd5, 6'b110011);
        chk(150, "fail_hold_b",  3'd5, 6'b110011);
        chk(179, "fail_hold_c",  3'd5, 6'b110011);
        for (int i = 80; i < 180; i++) begin
            goto(i);
            ddr_done = i[0];
            net_done = i[0];
        end
        ddr_done = 1'b0;
        net_done = 1'b0;

        // Reset exits FAIL; then reset mid NET_WAIT after one timeout
        do_reset();
        chk(39, "s4_to1",       3'd0, 6'b110010);
        chk(47, "s4_ddr",       3'd1, 6'b010010);
        chk(49, "s4_ddr_sync",  3'd1, 6'b010010);
        chk(50, "s4_net_wait",  3'd2, 6'b000010);
        chk(52, "s4_net_hold",  3'd2, 6'b000010);
        goto(47); ddr_done = 1'b1;
        goto(52); ddr_done = 1'b0;
        do_reset();
        chk(38, "s4_to1_again_pend", 3'd1, 6'b010000);
        chk(39, "s4_retry_cleared",  3'd0, 6'b110010);
        chk(78, "s4_to2_pend",       3'd1, 6'b010010);
        chk(79, "s4_fail",           3'd5, 6'b110011);
        goto(79);

        // Done and timeout in the same cycle: done wins
        do_reset();
        chk(38, "s5_ddr_wait",  3'd1, 6'b010000);
        chk(39, "s5_done_wins", 3'd2, 6'b000000);
        chk(70, "s5_net_wait",  3'd2, 6'b000000);
        chk(71, "s5_net_to",    3'd0, 6'b110010);
        goto(36); ddr_done = 1'b1;
        goto(71);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge sys_clk);
            #1;
        end
        while (sb.size() > 0) begin
            n_tot = n_tot + 1;
            $display("FAIL %s: expectation for cycle %0d never checked", sb_name[0], sb[0].at);
            void'(sb.pop_front());
            void'(sb_name.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
